// File: rtl/mp_add_ctrl_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package mp_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Chunk index width: ceil(log2(n)), but never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mp_add_ctrl_rca.sv
// Ripple-carry adder shared across all chunks of a multi-precision operation.
module mp_add_ctrl_rca #(
    parameter int DATA_WID = 16
) (
    input  logic [DATA_WID-1:0] A,
    input  logic [DATA_WID-1:0] B,
    input  logic                CarryInput,
    output logic [DATA_WID-1:0] Sum,
    output logic                CarryOutput
);

    logic c;

    always_comb begin
        Sum = '0;
        c   = CarryInput;
        for (int unsigned i = 0; i < DATA_WID; i++) begin
            Sum[i] = A[i] ^ B[i] ^ c;
            c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        CarryOutput = c;
    end

endmodule

// File: rtl/mp_add_ctrl.sv
// Multi-precision add/subtract sequencer: one narrow RCA reused over NUM_CHUNKS
// cycles with the carry registered between chunks; valid/ready on both sides.
module mp_add_ctrl
    import mp_add_ctrl_pkg::*;
#(
    parameter  int CHUNK_WID  = 16,
    parameter  int NUM_CHUNKS = 4,
    localparam int OPD_WID    = CHUNK_WID * NUM_CHUNKS
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic [OPD_WID-1:0] OperandA,
    input  logic [OPD_WID-1:0] OperandB,
    input  logic               Subtract,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [OPD_WID-1:0] Result,
    output logic               CarryOut,
    output logic               Overflow,
    output logic               Busy
);

    localparam int                 IDX_WID  = int'(idx_width(NUM_CHUNKS));
    localparam logic [IDX_WID-1:0] LAST_IDX = IDX_WID'(NUM_CHUNKS - 1);

    state_t               state, state_next;
    logic [OPD_WID-1:0]   a_reg, b_reg, result;
    logic [IDX_WID-1:0]   idx;
    logic                 carry, carry_out, overflow;
    logic [CHUNK_WID-1:0] a_chunk, b_chunk, sum;
    logic                 rca_co;
    logic                 accept, last;

    assign accept  = (state == ST_IDLE) && InValid;
    assign last    = (idx == LAST_IDX);
    assign a_chunk = a_reg[32'(idx) * CHUNK_WID +: CHUNK_WID];
    assign b_chunk = b_reg[32'(idx) * CHUNK_WID +: CHUNK_WID];

    mp_add_ctrl_rca #(.DATA_WID(CHUNK_WID)) u_rca (
        .A           (a_chunk),
        .B           (b_chunk),
        .CarryInput  (carry),
        .Sum         (sum),
        .CarryOutput (rca_co)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (InValid)  state_next = ST_RUN;
            ST_RUN:  if (last)     state_next = ST_DONE;
            ST_DONE: if (OutReady) state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // Subtract is folded in at acceptance: B is inverted and the +1 enters as carry-in.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            result    <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_reg <= OperandA;
            b_reg <= Subtract ? ~OperandB : OperandB;
            carry <= Subtract;
            idx   <= '0;
        end else if (state == ST_RUN) begin
            result[32'(idx) * CHUNK_WID +: CHUNK_WID] <= sum;
            carry <= rca_co;
            if (last) begin
                idx       <= '0;
                carry_out <= rca_co;
                overflow  <= (a_reg[OPD_WID-1] == b_reg[OPD_WID-1]) &&
                             (sum[CHUNK_WID-1] != a_reg[OPD_WID-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign InReady  = (state == ST_IDLE);
    assign OutValid = (state == ST_DONE);
    assign Busy     = (state != ST_IDLE);
    assign Result   = result;
    assign CarryOut = carry_out;
    assign Overflow = overflow;

endmodule

// File: tb/tb_mp_add_ctrl.sv
// Self-checking bench for mp_add_ctrl: directed vectors, random operations
// against an arithmetic reference, backpressure and mid-operation reset.
module tb_mp_add_ctrl;

    localparam int CW = 16;
    localparam int NC = 4;
    localparam int W  = CW * NC;

    logic         Clock = 1'b0;
    logic         Reset_n = 1'b0;
    logic         InValid = 1'b0;
    logic         OutReady = 1'b1;
    logic         Subtract = 1'b0;
    logic [W-1:0] OperandA = '0;
    logic [W-1:0] OperandB = '0;
    logic         InReady, OutValid, CarryOut, Overflow, Busy;
    logic [W-1:0] Result;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[6];

    mp_add_ctrl #(.CHUNK_WID(CW), .NUM_CHUNKS(NC)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .OperandA (OperandA),
        .OperandB (OperandB),
        .Subtract (Subtract),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
        .CarryOut (CarryOut),
        .Overflow (Overflow),
        .Busy     (Busy)
    );

    always #5 Clock = ~Clock;

    // Reference: exact integer arithmetic; overflow when the signed result does not fit.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  output logic [W-1:0] res, output logic co, output logic ov);
        logic [W:0]            wide;
        logic signed [W+1:0]   exact;
        logic signed [W+1:0]   trunc;
        if (sub) begin
            wide  = {1'b0, a} - {1'b0, b};
            co    = (a >= b);
            exact = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
        end else begin
            wide  = {1'b0, a} + {1'b0, b};
            co    = wide[W];
            exact = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
        end
        res   = wide[W-1:0];
        trunc = $signed({{2{res[W-1]}}, res});
        ov    = (exact != trunc);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int guard;
        @(negedge Clock);
        OperandA = a;
        OperandB = b;
        Subtract = sub;
        InValid  = 1'b1;
        guard    = 0;
        while (!InReady && guard < 50) begin
            @(negedge Clock);
            guard++;
        end
        check("accept_wait", 64'(guard < 50), 64'd1);
        @(posedge Clock);
        #1;
        InValid  = 1'b0;
        OperandA = {$urandom(), $urandom()};
        OperandB = {$urandom(), $urandom()};
        Subtract = $urandom_range(0, 1) == 1;
        check("busy_after_accept", 64'(Busy), 64'd1);
        check("inready_after_accept", 64'(InReady), 64'd0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!OutValid && lat <= 20) begin
            @(posedge Clock);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic [W-1:0] res, input logic co, input logic ov);
        int lat;
        OutReady = 1'b1;
        start_op(a, b, sub);
        wait_valid(lat);
        check({name, "_latency"}, 64'(lat), 64'(NC));
        check({name, "_result"}, Result, res);
        check({name, "_carry"}, 64'(CarryOut), 64'(co));
        check({name, "_ovf"}, 64'(Overflow), 64'(ov));
        @(posedge Clock);
        #1;
        check({name, "_valid_1cyc"}, 64'(OutValid), 64'd0);
        check({name, "_ready_back"}, 64'(InReady), 64'd1);
    endtask

    initial begin
        logic [W-1:0] a, b, r1, r2;
        logic         s, c1, v1, c2, v2;
        int           lat, bad;

        vecs[0] = '{"carry16",  64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{"ripple",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0,                   1'b1, 1'b0};
        vecs[2] = '{"borrow",   64'd5,                   64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{"noborrow", 64'd7,                   64'd5, 1'b1, 64'd2,                   1'b1, 1'b0};
        vecs[4] = '{"posovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[5] = '{"negovf",   64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

        #12;
        check("rst_inready", 64'(InReady), 64'd1);
        check("rst_outvalid", 64'(OutValid), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_result", Result, 64'd0);
        check("rst_carry", 64'(CarryOut), 64'd0);
        check("rst_ovf", 64'(Overflow), 64'd0);
        Reset_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, vecs[i].co, vecs[i].ov);

        for (int i = 0; i < 40; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            if (i % 5 == 0) b = ~a;
            if (i % 7 == 0) a[W-1] = b[W-1];
            s = $urandom_range(0, 1) == 1;
            model(a, b, s, r1, c1, v1);
            run_vec("rand", a, b, s, r1, c1, v1);
        end

        // Backpressure: hold the first result while a second request waits.
        a = 64'h1234_5678_9ABC_DEF0;
        b = 64'hFEDC_BA98_7654_3210;
        model(a, b, 1'b0, r1, c1, v1);
        OutReady = 1'b0;
        start_op(a, b, 1'b0);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'(NC));
        a = 64'h0F0F_0F0F_F0F0_F0F0;
        b = 64'h1111_2222_3333_4444;
        model(a, b, 1'b1, r2, c2, v2);
        OperandA = a;
        OperandB = b;
        Subtract = 1'b1;
        InValid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            check("bp_result_hold", Result, r1);
            check("bp_valid_hold", 64'(OutValid), 64'd1);
            check("bp_inready", 64'(InReady), 64'd0);
            check("bp_busy", 64'(Busy), 64'd1);
        end
        check("bp_carry", 64'(CarryOut), 64'(c1));
        check("bp_ovf", 64'(Overflow), 64'(v1));
        OutReady = 1'b1;
        @(posedge Clock);
        #1;
        OutReady = 1'b0;
        check("bp_release_valid", 64'(OutValid), 64'd0);
        check("bp_release_ready", 64'(InReady), 64'd1);
        @(posedge Clock);
        #1;
        InValid  = 1'b0;
        OperandA = '0;
        OperandB = '0;
        check("bp_second_accepted", 64'(Busy), 64'd1);
        wait_valid(lat);
        check("bp2_latency", 64'(lat), 64'(NC));
        check("bp2_result", Result, r2);
        check("bp2_carry", 64'(CarryOut), 64'(c2));
        check("bp2_ovf", 64'(Overflow), 64'(v2));
        OutReady = 1'b1;
        @(posedge Clock);
        #1;

        // Reset while the third chunk is about to be processed.
        start_op(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_1111_1111_1111, 1'b0);
        @(posedge Clock);
        @(posedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        check("mrst_outvalid", 64'(OutValid), 64'd0);
        check("mrst_result", Result, 64'd0);
        check("mrst_inready", 64'(InReady), 64'd1);
        check("mrst_busy", 64'(Busy), 64'd0);
        #2;
        Reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock);
            #1;
            if (OutValid || Busy) bad++;
        end
        check("mrst_no_valid", 64'(bad), 64'd0);
        a = 64'h0000_FFFF_0000_FFFF;
        b = 64'h0000_0001_0000_0001;
        model(a, b, 1'b0, r1, c1, v1);
        run_vec("post_rst", a, b, 1'b0, r1, c1, v1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mp_add_ctrl.md
Name: mp_add_ctrl

Overview:
Multi-precision add/subtract sequencer. One narrow RCA instance is reused over several clock cycles to add operands that are NUM_CHUNKS times wider than the adder. The carry is registered between chunks. Operands enter through a valid/ready input handshake, and results leave through a valid/ready output handshake. The block sits between an operand source, such as a register file or crypto/bignum datapath, and the consumer of wide sums.

Parameters:
CHUNK_WID, 16, width of the shared RCA instance in bits (DATA_WID of the adder)
NUM_CHUNKS, 4, number of chunks per operation; minimum 1
OPD_WID, CHUNK_WID*NUM_CHUNKS, total operand width; derived, must not be overridden

Ports:
Clock  input  1  single clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
InValid  input  1  request carries valid operands
InReady  output  1  block can accept a request
OperandA  input  OPD_WID  minuend / addend A
OperandB  input  OPD_WID  subtrahend / addend B
Subtract  input  1  1 = A-B, 0 = A+B; sampled with the operands
OutValid  output  1  Result, CarryOut and Overflow are valid
OutReady  input  1  consumer accepts the result
Result  output  OPD_WID  A+B or A-B, modulo 2^OPD_WID
CarryOut  output  1  unsigned carry out of the MSB; for subtract, 1 = no borrow
Overflow  output  1  two's-complement signed overflow
Busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, synchronous release handled by flops):
  - state=IDLE, InReady=1, OutValid=0, Busy=0.
  - Result=0, CarryOut=0, Overflow=0, chunk index=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - InReady=1.
  - On an edge with InValid&InReady, latch OperandA, the effective B and Subtract.
    - Effective B = OperandB when Subtract=0; ~OperandB when Subtract=1.
  - On the same edge: carry register := Subtract, index := 0, state goes to RUN.
- RUN:
  - InReady=0.
  - Each cycle the RCA receives chunk[index] of latched A, chunk[index] of effective B, and the carry register.
  - On each edge:
    - Result chunk[index] := RCA Sum.
    - Carry register := RCA CarryOutput.
    - index := index+1.
  - On the edge that processes index NUM_CHUNKS-1:
    - CarryOut := RCA CarryOutput.
    - Overflow := (A_msb == Beff_msb) && (Sum_msb != A_msb).
    - State goes to DONE.
- DONE:
  - OutValid=1. Result, CarryOut and Overflow are held stable while OutReady=0.
  - On an edge with OutReady=1, OutValid falls and state goes to IDLE.
  - Result keeps its value until the next operation overwrites its chunks.
- Latency: OutValid rises exactly NUM_CHUNKS clocks after the acceptance edge. With OutReady held high, throughput is one operation per NUM_CHUNKS+2 clocks.
- Input stability: changes on OperandA/OperandB/Subtract after acceptance have no effect. InValid in RUN or DONE is ignored because InReady=0.
- InReady is combinational from state only (IDLE). OutValid and Busy are decoded from registered state. No input-to-output combinational path exists.
- NUM_CHUNKS=1: RUN lasts one cycle; the carry chain is a single RCA pass.
- Index counter width is clog2(NUM_CHUNKS), minimum 1. It never exceeds NUM_CHUNKS-1, and no wrap occurs inside an operation.
- Reset mid-operation (RUN or DONE):
  - Immediate return to IDLE, with all outputs at their reset values.
  - The partial result is discarded. No OutValid pulse occurs after release.

Decomposition:
- Shared package:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - A clog2 function for the index width.
- Sub-module: the existing RCA module, instantiated once with DATA_WID=CHUNK_WID and CarryInput driven from the carry register.
- No other sub-module. Chunk select and the Result write are generate/indexed part-selects inside mp_add_ctrl.

Test Plan:
All scenarios use CHUNK_WID=16, NUM_CHUNKS=4 and OutReady=1 unless stated.
- A=0x0000_0000_0000_FFFF, B=1, Subtract=0 -> Result=0x0000_0000_0001_0000, CarryOut=0, Overflow=0. OutValid rises 4 clocks after the acceptance edge and lasts 1 cycle.
- A=0xFFFF_FFFF_FFFF_FFFF, B=1, add -> Result=0, CarryOut=1, Overflow=0. This checks that the carry ripples across all 4 chunks.
- A=5, B=7, Subtract=1 -> Result=0xFFFF_FFFF_FFFF_FFFE, CarryOut=0 (borrow), Overflow=0. Separately, A=7, B=5, Subtract=1 -> Result=2, CarryOut=1.
- A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> Result=0x8000_0000_0000_0000, Overflow=1, CarryOut=0. Separately, A=0x8000_0000_0000_0000, B=1, Subtract=1 -> Result=0x7FFF_FFFF_FFFF_FFFF, Overflow=1.
- Backpressure: OutReady=0 for 10 cycles after OutValid rises, with InValid held high and new operands applied.
  - Result is stable, InReady=0, Busy=1, and the second request is not accepted.
  - After the OutReady pulse, InReady=1 in the next cycle and the second request completes with its own correct result.
- Reset_n pulsed low during the RUN cycle where index=2:
  - Asynchronously: OutValid=0, Result=0, InReady=1.
  - After release, no OutValid appears until a new request is accepted; that request yields a correct result.
